ddr_rd_burst_axi_bridge: RTL and testbench

//  Responder side of the rd_burst_* read interface used by the weight FIFOs: accepts one burst request (addr, len) at a time.

---
 rtl/ddr_rd_burst_axi_bridge_pkg.sv | 23 ++
 rtl/axi_rd_resp_checker.sv | 35 +++
 rtl/ddr_rd_burst_axi_bridge.sv | 127 ++++++++++++
 tb/tb_ddr_rd_burst_axi_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_burst_axi_bridge_pkg.sv
// Shared constants for the rd_burst-to-AXI4 read bridge: default widths,
// AXI burst/response encodings and the ARSIZE helper.
package ddr_rd_burst_axi_bridge_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_SIZE  = 32;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI size code for a power-of-two bytes-per-beat value.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_rd_resp_checker.sv
// Sticky protocol-error flag for AXI read beats: non-OKAY response, rlast on
// the wrong beat (or missing on the final one), or an unexpected RID.
module axi_rd_resp_checker
  import ddr_rd_burst_axi_bridge_pkg::*;
#(
  parameter int                      P_LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int                      P_ID_WIDTH  = AXI_ID_WIDTH,
  parameter logic [P_ID_WIDTH-1:0]   P_AXI_ID    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   beat,
  input  logic [P_LEN_WIDTH:0]   beat_idx,
  input  logic [P_LEN_WIDTH:0]   len,
  input  logic [1:0]             resp,
  input  logic                   last,
  input  logic [P_ID_WIDTH-1:0]  id,
  output logic                   err
);

  logic bad;

  always_comb begin
    bad = (resp != AXI_RESP_OKAY) || (last != (beat_idx == len)) || (id != P_AXI_ID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (beat && bad) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_rd_burst_axi_bridge.sv
// Bridges one rd_burst request at a time onto a single AXI4 INCR read.
// Optional response checking is enabled with DDR_RD_RESP_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for rd_burst_req, latches addr/len
// ADDR  | AR channel valid until arready
// DATA  | rready high, forwarding beats until count reaches len
// FIN   | rd_burst_finish pulse
// GUARD | dead cycle while requester drops req
module ddr_rd_burst_axi_bridge
  import ddr_rd_burst_axi_bridge_pkg::*;
#(
  parameter int                      P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                      P_ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int                      P_LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter logic [AXI_ID_WIDTH-1:0] P_AXI_ID     = '0
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     rd_burst_req,
  input  logic [P_ADDR_SIZE-1:0]   rd_burst_addr,
  // one extra bit so both 0 and a full 256-beat burst are expressible
  input  logic [P_LEN_WIDTH:0]     rd_burst_len,
  output logic [P_DATA_WIDTH-1:0]  rd_burst_data,
  output logic                     rd_burst_valid,
  output logic                     rd_burst_finish,
  output logic [AXI_ID_WIDTH-1:0]  m_axi_arid,
  output logic [P_ADDR_SIZE-1:0]   m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]  m_axi_rid,
  input  logic [P_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic                     o_rd_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  localparam logic [2:0] ARSIZE = axi_size(P_DATA_WIDTH / 8);

  logic [2:0]             state;
  logic [P_ADDR_SIZE-1:0] addr_q;
  logic [P_LEN_WIDTH:0]   len_q;
  logic [P_LEN_WIDTH:0]   len_m1;
  logic [P_LEN_WIDTH:0]   beat_cnt;
  logic                   beat;

  // Beats beyond len are dropped so a misbehaving slave cannot overrun the count.
  assign beat   = (state == S_DATA) && m_axi_rvalid && (beat_cnt != len_q);
  assign len_m1 = len_q - 1'b1;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      beat_cnt       <= '0;
      rd_burst_data  <= '0;
      rd_burst_valid <= 1'b0;
    end else begin
      rd_burst_valid <= beat;
      if (beat) rd_burst_data <= m_axi_rdata;
      case (state)
        S_IDLE: begin
          if (rd_burst_req) begin
            addr_q   <= rd_burst_addr;
            len_q    <= rd_burst_len;
            beat_cnt <= '0;
            state    <= (rd_burst_len == '0) ? S_FIN : S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi_arready) state <= S_DATA;
        end
        S_DATA: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == len_q) state <= S_FIN;
        end
        S_FIN:   state <= S_GUARD;
        S_GUARD: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axi_arvalid   = (state == S_ADDR);
  assign m_axi_araddr    = m_axi_arvalid ? addr_q : '0;
  assign m_axi_arlen     = m_axi_arvalid ? 8'(len_m1) : '0;
  assign m_axi_arsize    = m_axi_arvalid ? ARSIZE : '0;
  assign m_axi_arburst   = m_axi_arvalid ? AXI_BURST_INCR : '0;
  assign m_axi_arid      = m_axi_arvalid ? P_AXI_ID : '0;
  assign m_axi_rready    = (state == S_DATA);
  assign rd_burst_finish = (state == S_FIN);

`ifdef DDR_RD_RESP_CHECK_EN
  axi_rd_resp_checker #(
    .P_LEN_WIDTH (P_LEN_WIDTH),
    .P_ID_WIDTH  (AXI_ID_WIDTH),
    .P_AXI_ID    (P_AXI_ID)
  ) u_resp_checker (
    .clk      (s_clk),
    .rst_n    (s_rst_n),
    .beat     (beat),
    .beat_idx (beat_cnt + 1'b1),
    .len      (len_q),
    .resp     (m_axi_rresp),
    .last     (m_axi_rlast),
    .id       (m_axi_rid),
    .err      (o_rd_err)
  );
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_rresp, m_axi_rlast, m_axi_rid};
  assign o_rd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_burst_axi_bridge.sv
// Self-checking bench for ddr_rd_burst_axi_bridge: table of bursts plus
// back-to-back, mid-burst reset and response-error sequences.
module tb_ddr_rd_burst_axi_bridge;

`ifdef DDR_RD_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        s_clk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        rd_burst_req = 1'b0;
  logic [31:0] rd_burst_addr = '0;
  logic [8:0]  rd_burst_len = '0;
  logic [63:0] rd_burst_data;
  logic        rd_burst_valid, rd_burst_finish;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [3:0]  m_axi_rid = '0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic        o_rd_err;

  ddr_rd_burst_axi_bridge dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data(rd_burst_data), .rd_burst_valid(rd_burst_valid), .rd_burst_finish(rd_burst_finish),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .o_rd_err(o_rd_err)
  );

  always #5 s_clk = ~s_clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int valid_cnt = 0, finish_cnt = 0, cyc = 0, last_valid_cyc = 0, fin_cyc = 0;
  bit exp_err = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          ar_delay;
    bit          toggle;
    logic [7:0]  exp_arlen;
    int          exp_ar;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each returned beat.
  always @(negedge s_clk) begin
    cyc++;
    if (rd_burst_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=0x%0h required=none", rd_burst_data);
      end else begin
        check("beat_data", rd_burst_data, exp_q.pop_front());
      end
    end
    if (rd_burst_finish) begin
      finish_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic run_burst(input logic [31:0] addr, input int len, input int ar_delay,
                           input bit toggle, input logic [7:0] exp_arlen, input int exp_ar,
                           input int err_beat, input int rlast_beat, input int rst_beat,
                           input bit chain, input logic [31:0] tag);
    int ar_hs = 0, ar_wait = 0, sent = 0, iter = 0, fin_iter = -1, rready_drop = 0;
    bit tog = 1'b1, data_phase = 1'b0, ar_prev = 1'b0, done = 1'b0;
    valid_cnt = 0; finish_cnt = 0; last_valid_cyc = 0; fin_cyc = 0;
    rd_burst_req  = 1'b1;
    rd_burst_addr = addr;
    rd_burst_len  = 9'(len);
    while (!done) begin
      if (ar_prev) data_phase = 1'b1;
      ar_prev = 1'b0;
      if (rst_beat != 0 && sent == rst_beat) begin
        s_rst_n = 1'b0;
        rd_burst_req = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rlast = 1'b0;
        exp_q.delete();
        #1;
        check("abort_data", rd_burst_data, 64'd0);
        check("abort_ctrl", {rd_burst_valid, rd_burst_finish, m_axi_arvalid, m_axi_rready,
                             o_rd_err, m_axi_arlen, m_axi_arsize, m_axi_arburst}, 64'd0);
        check("abort_araddr", m_axi_araddr, 64'd0);
        repeat (3) begin @(posedge s_clk); #1; end
        check("abort_no_finish", finish_cnt, 64'd0);
        s_rst_n = 1'b1;
        exp_err = 1'b0;
        return;
      end
      m_axi_arready = 1'b0;
      if (m_axi_arvalid) begin
        if (ar_wait >= ar_delay) begin
          m_axi_arready = 1'b1;
          ar_hs++;
          ar_prev = 1'b1;
          check("araddr", m_axi_araddr, addr);
          check("arlen", m_axi_arlen, exp_arlen);
          check("arsize", m_axi_arsize, 64'd3);
          check("arburst", m_axi_arburst, 64'd1);
          check("arid", m_axi_arid, 64'd0);
        end else begin
          ar_wait++;
        end
      end
      if (data_phase && sent < len && !m_axi_rready) rready_drop++;
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      if (m_axi_rready && sent < len) begin
        if (!toggle || tog) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = {tag, 32'(sent)};
          m_axi_rlast  = (rlast_beat != 0) ? (sent + 1 == rlast_beat) : (sent + 1 == len);
          if (sent + 1 == err_beat) m_axi_rresp = 2'b10;
          if (CHK && ((sent + 1 == err_beat) ||
                      (rlast_beat != 0 && sent + 1 == rlast_beat && rlast_beat != len)))
            exp_err = 1'b1;
          exp_q.push_back(m_axi_rdata);
          sent++;
        end
        tog = !tog;
      end
      if (rd_burst_finish) begin
        if (fin_iter < 0) fin_iter = iter;
        rd_burst_req = 1'b0;
      end
      @(posedge s_clk); #1;
      iter++;
      if (fin_iter >= 0 && (chain || iter >= fin_iter + 4)) done = 1'b1;
      if (iter > 3000) begin
        checks++;
        errors++;
        $display("FAIL burst_timeout actual=no_finish required=finish addr=0x%0h", addr);
        rd_burst_req = 1'b0;
        done = 1'b1;
      end
    end
    m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rlast = 1'b0;
    check("ar_count", ar_hs, exp_ar);
    check("valid_count", valid_cnt, len);
    check("finish_count", finish_cnt, 64'd1);
    if (len > 0) check("finish_after_last_valid", fin_cyc - last_valid_cyc, 64'd1);
    else         check("finish_latency_len0", fin_iter, 64'd1);
    check("rready_in_data", rready_drop, 64'd0);
    check("queue_empty", exp_q.size(), 64'd0);
    check("rd_err", o_rd_err, exp_err);
  endtask

  initial begin
    vecs[0] = '{32'h1000_0000,  32, 3, 1'b0, 8'd31,  1};
    vecs[1] = '{32'h1000_0000,  32, 0, 1'b1, 8'd31,  1};
    vecs[2] = '{32'h2000_0040,   0, 0, 1'b0, 8'd0,   0};
    vecs[3] = '{32'h3000_0000, 256, 1, 1'b0, 8'd255, 1};
    vecs[4] = '{32'h0000_0008,   1, 0, 1'b1, 8'd0,   1};

    repeat (3) @(posedge s_clk);
    #1;
    check("reset_data", rd_burst_data, 64'd0);
    check("reset_ctrl", {rd_burst_valid, rd_burst_finish, m_axi_arvalid, m_axi_rready,
                         o_rd_err, m_axi_arlen, m_axi_arsize, m_axi_arburst}, 64'd0);
    check("reset_araddr", m_axi_araddr, 64'd0);
    s_rst_n = 1'b1;
    @(posedge s_clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].ar_delay, vecs[i].toggle,
                vecs[i].exp_arlen, vecs[i].exp_ar, 0, 0, 0, 1'b0, 32'hA000 + 32'(i));
    end

    // Requester drops req on finish, reasserts next cycle with the next page chunk.
    run_burst(32'h1000_0000, 32, 1, 1'b0, 8'd31, 1, 0, 0, 0, 1'b1, 32'hB001);
    run_burst(32'h1000_0100, 32, 0, 1'b0, 8'd31, 1, 0, 0, 0, 1'b0, 32'hB002);

    // Reset during beat 10, then a clean burst.
    run_burst(32'h4000_0000, 32, 0, 1'b0, 8'd31, 1, 0, 0, 10, 1'b0, 32'hC001);
    run_burst(32'h4000_0800, 32, 2, 1'b1, 8'd31, 1, 0, 0, 0, 1'b0, 32'hC002);

    // SLVERR on beat 5, then a clean burst: flag must hold.
    run_burst(32'h5000_0000, 32, 0, 1'b0, 8'd31, 1, 5, 0, 0, 1'b0, 32'hD001);
    run_burst(32'h5000_0100, 16, 0, 1'b0, 8'd15, 1, 0, 0, 0, 1'b0, 32'hD002);

    s_rst_n = 1'b0;
    @(posedge s_clk); #1;
    check("err_cleared_by_reset", o_rd_err, 64'd0);
    s_rst_n = 1'b1;
    exp_err = 1'b0;
    @(posedge s_clk); #1;

    // Early rlast on beat 31 of 32.
    run_burst(32'h6000_0000, 32, 0, 1'b1, 8'd31, 1, 0, 31, 0, 1'b0, 32'hE001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
